// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer
// Reads 4-bit subpixels from the frame-buffer read port in groups of four,
// packs nibble pairs into bytes and streams them to the LCD serial
// transmitter. The RAMWR command byte is sent first in every frame.
// Frame-buffer reads are throttled against a small local nibble FIFO, so
// transmitter backpressure never loses data.
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   FRAME_START pulse, starts one frame when idle
//   PIX_EN      frame-buffer read enable (one nibble per high cycle)
//   PIX_DATA    frame-buffer output, subpixel in [7:4]
//   BYTE_DATA   byte to the transmitter
//   BYTE_DC     0 = command, 1 = data
//   BYTE_VALID  BYTE_DATA/BYTE_DC valid
//   BYTE_READY  transmitter accepts the byte this cycle
//   BUSY        frame in progress
//   FRAME_DONE  one-cycle pulse after the last data byte is accepted
module lcd_frame_streamer #(
    parameter int         FRAME_NIBBLES = 172800,
    parameter int         RD_LATENCY    = 5,
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] RAMWR_CMD     = 8'h2C
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FRAME_START,
    output logic       PIX_EN,
    input  logic [7:0] PIX_DATA,
    output logic [7:0] BYTE_DATA,
    output logic       BYTE_DC,
    output logic       BYTE_VALID,
    input  logic       BYTE_READY,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = AW + 1;
    localparam int LAST_BYTE = FRAME_NIBBLES / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic                  pix_en_reg, pix_en_next;
    logic [1:0]            grp_phase_reg, grp_phase_next;
    logic [17:0]           req_cnt_reg, req_cnt_next;
    logic [PW-1:0]         inflight_reg, inflight_next;
    logic [RD_LATENCY-1:0] rd_pipe_reg, rd_pipe_in;
    logic [3:0]            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_next, fifo_cnt;
    logic [AW-1:0]         rd_idx0, rd_idx1;
    logic [7:0]            byte_data_reg, byte_data_next;
    logic                  byte_dc_reg, byte_dc_next;
    logic                  byte_valid_reg, byte_valid_next;
    logic [17:0]           data_cnt_reg, data_cnt_next;
    logic                  capture, accept, pop, group_ok;
    logic [17:0]           req_after;
    logic [PW+1:0]         reserve;
    logic                  unused_pix_low;

    assign unused_pix_low = &{1'b0, PIX_DATA[3:0]};

    // Read-latency tracker: a 1 leaving the last stage marks a valid nibble.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign rd_pipe_in[gi] = pix_en_reg;
            end else begin : g_tail
                assign rd_pipe_in[gi] = rd_pipe_reg[gi-1];
            end
        end
    endgenerate

    assign capture  = rd_pipe_reg[RD_LATENCY-1];
    assign fifo_cnt = wr_ptr_reg - rd_ptr_reg;
    assign rd_idx0  = rd_ptr_reg[AW-1:0];
    assign rd_idx1  = rd_idx0 + AW'(1);
    assign accept   = byte_valid_reg && BYTE_READY;

    // A new group reserves FIFO space for everything already requested,
    // including the nibble being requested this very cycle, so the FIFO
    // cannot overflow whatever the transmitter does.
    assign req_after = req_cnt_reg + 18'(pix_en_reg);
    assign reserve   = {2'b00, fifo_cnt} + {2'b00, inflight_reg}
                     + (PW+2)'(pix_en_reg) + (PW+2)'(4);
    assign group_ok  = (state_reg == S_STREAM)
                     && (req_after < 18'(FRAME_NIBBLES))
                     && (reserve <= (PW+2)'(FIFO_DEPTH));

    assign pop = ((state_reg == S_STREAM) || (state_reg == S_DRAIN))
               && (!byte_valid_reg || BYTE_READY)
               && (fifo_cnt >= PW'(2));

    // Request side: groups of exactly four PIX_EN cycles.
    always_comb begin
        pix_en_next    = 1'b0;
        grp_phase_next = 2'd0;
        if (pix_en_reg && (grp_phase_reg != 2'd3)) begin
            pix_en_next    = 1'b1;
            grp_phase_next = grp_phase_reg + 2'd1;
        end else if (group_ok) begin
            pix_en_next    = 1'b1;
            grp_phase_next = 2'd0;
        end
    end

    assign inflight_next = inflight_reg + PW'(pix_en_reg) - PW'(capture);

    // Frame control, packer and output register.
    always_comb begin
        state_next      = state_reg;
        byte_data_next  = byte_data_reg;
        byte_dc_next    = byte_dc_reg;
        byte_valid_next = byte_valid_reg;
        data_cnt_next   = data_cnt_reg;
        rd_ptr_next     = rd_ptr_reg;
        req_cnt_next    = req_cnt_reg + 18'(pix_en_reg);

        if (accept && byte_dc_reg) begin
            data_cnt_next = data_cnt_reg + 18'd1;
        end

        if (pop) begin
            byte_data_next  = {fifo_mem[rd_idx0], fifo_mem[rd_idx1]};
            byte_dc_next    = 1'b1;
            byte_valid_next = 1'b1;
            rd_ptr_next     = rd_ptr_reg + PW'(2);
        end else if (accept) begin
            byte_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                req_cnt_next  = 18'd0;
                data_cnt_next = 18'd0;
                if (FRAME_START) begin
                    state_next      = S_CMD;
                    byte_data_next  = RAMWR_CMD;
                    byte_dc_next    = 1'b0;
                    byte_valid_next = 1'b1;
                end
            end
            S_CMD: begin
                if (accept) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (req_cnt_reg == 18'(FRAME_NIBBLES)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept && (data_cnt_reg == 18'(LAST_BYTE - 1))
                    && (inflight_reg == '0) && (fifo_cnt == '0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            pix_en_reg     <= 1'b0;
            grp_phase_reg  <= 2'd0;
            req_cnt_reg    <= 18'd0;
            inflight_reg   <= '0;
            rd_pipe_reg    <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            byte_data_reg  <= 8'd0;
            byte_dc_reg    <= 1'b0;
            byte_valid_reg <= 1'b0;
            data_cnt_reg   <= 18'd0;
        end else begin
            state_reg      <= state_next;
            pix_en_reg     <= pix_en_next;
            grp_phase_reg  <= grp_phase_next;
            req_cnt_reg    <= req_cnt_next;
            inflight_reg   <= inflight_next;
            rd_pipe_reg    <= rd_pipe_in;
            rd_ptr_reg     <= rd_ptr_next;
            byte_data_reg  <= byte_data_next;
            byte_dc_reg    <= byte_dc_next;
            byte_valid_reg <= byte_valid_next;
            data_cnt_reg   <= data_cnt_next;
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (capture) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= PIX_DATA[7:4];
        end
    end

    assign PIX_EN     = pix_en_reg;
    assign BYTE_DATA  = byte_data_reg;
    assign BYTE_DC    = byte_dc_reg;
    assign BYTE_VALID = byte_valid_reg;
    assign BUSY       = (state_reg == S_CMD) || (state_reg == S_STREAM)
                     || (state_reg == S_DRAIN);
    assign FRAME_DONE = (state_reg == S_DONE);

endmodule
